// File: rtl/sopc_scope_sys_nios2_qsys_0_ocimem_arbiter.sv
// rtl/sopc_scope_sys_nios2_qsys_0_ocimem_arbiter.sv - round-robin JTAG/Avalon arbiter for the debug RAM port
module sopc_scope_sys_nios2_qsys_0_ocimem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    // JTAG command side (already synchronised into clk)
    input  logic        jtag_addr_load,
    input  logic [7:0]  jtag_addr_in,
    input  logic        jtag_req,
    input  logic        jtag_wr,
    input  logic [31:0] jtag_wdata,
    input  logic        jtag_ovf_clr,
    output logic [31:0] jtag_rdata,
    output logic        jtag_rdata_valid,
    output logic        jtag_busy,
    output logic        jtag_overflow,
    // Avalon debug slave
    input  logic [7:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic [3:0]  av_byteenable,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    // Single-port RAM, 1-cycle read latency
    output logic        ram_en,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } state_t;

    state_t      state;

    // One-entry JTAG holding buffer
    logic        pend_valid;
    logic        pend_wr;
    logic [31:0] pend_wdata;

    logic [7:0]  jtag_addr;

    // Owner and direction of the access currently in flight
    logic        cur_jtag;
    logic        cur_wr;

    // 1 = JTAG was granted most recently, 0 = Avalon
    logic        last_grant_jtag;

    logic        jtag_want;
    logic        av_want;
    logic        grant_jtag;
    logic        grant_av;
    logic        sel_wr;
    logic [31:0] sel_wdata;
    logic        jtag_done;
    logic        av_done;
    logic        jtag_drop;

    // A fresh jtag_req can be granted in the very cycle it arrives; the
    // holding buffer always has priority over the live pulse.
    assign jtag_want = pend_valid | jtag_req;
    assign av_want   = av_read | av_write;
    assign sel_wr    = pend_valid ? pend_wr    : jtag_wr;
    assign sel_wdata = pend_valid ? pend_wdata : jtag_wdata;

    // Grant decision, only meaningful in IDLE; ties go to whoever lost last
    always_comb begin
        grant_jtag = 1'b0;
        grant_av   = 1'b0;
        if (state == ST_IDLE) begin
            grant_jtag = jtag_want & (~av_want   | ~last_grant_jtag);
            grant_av   = av_want   & (~jtag_want |  last_grant_jtag);
        end
    end

    // Completion: writes finish in ACCESS, reads in RDATA
    always_comb begin
        jtag_done = 1'b0;
        av_done   = 1'b0;
        if ((state == ST_ACCESS && cur_wr) || state == ST_RDATA) begin
            jtag_done = cur_jtag;
            av_done   = ~cur_jtag;
        end
    end

    // A request that finds the buffer full and not draining this cycle is lost
    assign jtag_drop = jtag_req & pend_valid & ~grant_jtag;

    assign av_waitrequest = ~av_done;
    assign av_readdata    = ram_rdata;
    assign jtag_busy      = pend_valid | ((state != ST_IDLE) & cur_jtag);

    // JTAG holding buffer: fill on request, drain on grant, refill if both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_wdata <= 32'h0;
        end else begin
            if (grant_jtag) begin
                pend_valid <= pend_valid & jtag_req;
            end else if (jtag_req) begin
                pend_valid <= 1'b1;
            end
            if (jtag_req && (!pend_valid || grant_jtag)) begin
                pend_wr    <= jtag_wr;
                pend_wdata <= jtag_wdata;
            end
        end
    end

    // JTAG address pointer: explicit load beats the post-access increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr <= 8'h00;
        end else if (jtag_addr_load) begin
            jtag_addr <= jtag_addr_in;
        end else if (jtag_done) begin
            jtag_addr <= jtag_addr + 8'd1;
        end
    end

    // Sticky overflow flag: a new drop outranks a coincident clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_overflow <= 1'b0;
        end else if (jtag_drop) begin
            jtag_overflow <= 1'b1;
        end else if (jtag_ovf_clr) begin
            jtag_overflow <= 1'b0;
        end
    end

    // Access sequencer: owns the registered RAM port and JTAG read return
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            ram_en           <= 1'b0;
            ram_we           <= 1'b0;
            ram_addr         <= 8'h00;
            ram_wdata        <= 32'h0;
            ram_be           <= 4'h0;
            cur_jtag         <= 1'b0;
            cur_wr           <= 1'b0;
            last_grant_jtag  <= 1'b0;
            jtag_rdata       <= 32'h0;
            jtag_rdata_valid <= 1'b0;
        end else begin
            ram_en           <= 1'b0;
            ram_we           <= 1'b0;
            jtag_rdata_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_jtag) begin
                        state           <= ST_ACCESS;
                        ram_en          <= 1'b1;
                        ram_we          <= sel_wr;
                        ram_addr        <= jtag_addr;
                        ram_wdata       <= sel_wdata;
                        ram_be          <= 4'hF;
                        cur_jtag        <= 1'b1;
                        cur_wr          <= sel_wr;
                        last_grant_jtag <= 1'b1;
                    end else if (grant_av) begin
                        state           <= ST_ACCESS;
                        ram_en          <= 1'b1;
                        ram_we          <= av_write;
                        ram_addr        <= av_address;
                        ram_wdata       <= av_writedata;
                        ram_be          <= av_byteenable;
                        cur_jtag        <= 1'b0;
                        cur_wr          <= av_write;
                        last_grant_jtag <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    state <= cur_wr ? ST_IDLE : ST_RDATA;
                end
                ST_RDATA: begin
                    state <= ST_IDLE;
                    if (cur_jtag) begin
                        jtag_rdata       <= ram_rdata;
                        jtag_rdata_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_scope_sys_nios2_qsys_0_ocimem_arbiter.sv
// tb/tb_sopc_scope_sys_nios2_qsys_0_ocimem_arbiter.sv - self-checking bench for the debug RAM arbiter
module tb_sopc_scope_sys_nios2_qsys_0_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        jtag_addr_load = 1'b0;
    logic [7:0]  jtag_addr_in = 8'h00;
    logic        jtag_req = 1'b0;
    logic        jtag_wr = 1'b0;
    logic [31:0] jtag_wdata = 32'h0;
    logic        jtag_ovf_clr = 1'b0;
    logic [31:0] jtag_rdata;
    logic        jtag_rdata_valid;
    logic        jtag_busy;
    logic        jtag_overflow;
    logic [7:0]  av_address = 8'h00;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = 32'h0;
    logic [3:0]  av_byteenable = 4'h0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    sopc_scope_sys_nios2_qsys_0_ocimem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .jtag_addr_load   (jtag_addr_load),
        .jtag_addr_in     (jtag_addr_in),
        .jtag_req         (jtag_req),
        .jtag_wr          (jtag_wr),
        .jtag_wdata       (jtag_wdata),
        .jtag_ovf_clr     (jtag_ovf_clr),
        .jtag_rdata       (jtag_rdata),
        .jtag_rdata_valid (jtag_rdata_valid),
        .jtag_busy        (jtag_busy),
        .jtag_overflow    (jtag_overflow),
        .av_address       (av_address),
        .av_read          (av_read),
        .av_write         (av_write),
        .av_writedata     (av_writedata),
        .av_byteenable    (av_byteenable),
        .av_readdata      (av_readdata),
        .av_waitrequest   (av_waitrequest),
        .ram_en           (ram_en),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_be           (ram_be),
        .ram_rdata        (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural 256x32 RAM with byte enables and 1-cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    acc_t        exp_acc [$];
    logic [31:0] exp_jrd [$];
    logic [31:0] exp_avrd [$];
    acc_t        mon_e;
    logic [31:0] mon_d;
    int          n_tests = 0;
    int          n_fail = 0;
    int          jv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare DUT outputs against queued expectations
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_en) begin
                if (exp_acc.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ram_access: unexpected access addr %h we %b", ram_addr, ram_we);
                end else begin
                    mon_e = exp_acc.pop_front();
                    chk("ram_addr", 32'(ram_addr), 32'(mon_e.addr));
                    chk("ram_we", 32'(ram_we), 32'(mon_e.we));
                    chk("ram_be", 32'(ram_be), 32'(mon_e.be));
                    if (mon_e.we) chk("ram_wdata", ram_wdata, mon_e.wdata);
                end
            end
            if (jtag_rdata_valid) begin
                jv_count++;
                if (exp_jrd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL jtag_rdata_valid: unexpected pulse data %h", jtag_rdata);
                end else begin
                    mon_d = exp_jrd.pop_front();
                    chk("jtag_rdata", jtag_rdata, mon_d);
                end
            end
            if (av_read && !av_write && !av_waitrequest) begin
                if (exp_avrd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL av_readdata: unexpected completion data %h", av_readdata);
                end else begin
                    mon_d = exp_avrd.pop_front();
                    chk("av_readdata", av_readdata, mon_d);
                end
            end
        end
    end

    task automatic push_acc(input logic [7:0] a, input logic we, input logic [3:0] be, input logic [31:0] d);
        acc_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = d;
        exp_acc.push_back(e);
    endtask

    task automatic wait_jtag_idle(input string name);
        int ok;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!jtag_busy) begin ok = 1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic jtag_load(input logic [7:0] a);
        @(posedge clk); #1;
        jtag_addr_load = 1'b1; jtag_addr_in = a;
        @(posedge clk); #1;
        jtag_addr_load = 1'b0;
    endtask

    task automatic jtag_write(input logic [31:0] d, input logic [7:0] exp_addr);
        @(posedge clk); #1;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = d;
        push_acc(exp_addr, 1'b1, 4'hF, d);
        @(posedge clk); #1;
        jtag_req = 1'b0;
        wait_jtag_idle("jtag_write_done");
    endtask

    task automatic av_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int lat, output int lows);
        @(posedge clk); #1;
        av_read = ~wr; av_write = wr; av_address = a; av_writedata = d; av_byteenable = be;
        lat = 0; lows = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!av_waitrequest) begin lat = k; lows++; break; end
        end
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
        @(negedge clk);
        if (!av_waitrequest) lows++;
    endtask

    vec_t tbl [7];

    initial begin : main
        int lat, lows, first, pulses, done, jv0;

        tbl[0] = '{1'b1, 8'h20, 32'h12345678, 4'hF, 32'h0};
        tbl[1] = '{1'b1, 8'h20, 32'hAAAA5566, 4'h3, 32'h0};
        tbl[2] = '{1'b0, 8'h20, 32'h0,        4'hF, 32'h12345566};
        tbl[3] = '{1'b1, 8'h20, 32'hCCDD0000, 4'hC, 32'h0};
        tbl[4] = '{1'b0, 8'h20, 32'h0,        4'hF, 32'hCCDD5566};
        tbl[5] = '{1'b1, 8'h21, 32'hCAFEF00D, 4'hF, 32'h0};
        tbl[6] = '{1'b0, 8'h21, 32'h0,        4'hF, 32'hCAFEF00D};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_waitrequest", 32'(av_waitrequest), 32'd1);
        chk("rst_busy", 32'(jtag_busy), 32'd0);
        chk("rst_overflow", 32'(jtag_overflow), 32'd0);
        chk("rst_rdata_valid", 32'(jtag_rdata_valid), 32'd0);
        chk("rst_jtag_rdata", jtag_rdata, 32'h0);
        chk("rst_ram_ctl", {28'h0, ram_en, ram_we, 2'b00}, 32'h0);
        chk("rst_ram_addr_be", {20'h0, ram_addr, ram_be}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Avalon table: latency, single waitrequest-low cycle, byte enables
        for (int i = 0; i < 7; i++) begin
            push_acc(tbl[i].addr, tbl[i].wr, tbl[i].be, tbl[i].data);
            if (!tbl[i].wr) exp_avrd.push_back(tbl[i].exp_rd);
            av_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].be, lat, lows);
            chk($sformatf("av_lat[%0d]", i), 32'(lat), tbl[i].wr ? 32'd2 : 32'd3);
            chk($sformatf("av_wait_lows[%0d]", i), 32'(lows), 32'd1);
        end

        // JTAG write at a loaded address
        jtag_load(8'h10);
        @(posedge clk); #1;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hDEADBEEF;
        push_acc(8'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        @(posedge clk); #1;
        jtag_req = 1'b0;
        @(negedge clk);
        chk("jw_busy_access", 32'(jtag_busy), 32'd1);
        chk("jw_ram_en_we", {30'h0, ram_en, ram_we}, 32'd3);
        @(negedge clk);
        chk("jw_busy_after", 32'(jtag_busy), 32'd0);
        chk("jw_ram_en_after", 32'(ram_en), 32'd0);

        // JTAG read back: one valid pulse three cycles after the request
        jtag_load(8'h10);
        @(posedge clk); #1;
        jtag_req = 1'b1; jtag_wr = 1'b0;
        push_acc(8'h10, 1'b0, 4'hF, 32'h0);
        exp_jrd.push_back(32'hDEADBEEF);
        @(negedge clk);
        @(posedge clk); #1;
        jtag_req = 1'b0;
        first = 0; pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (jtag_rdata_valid) begin
                if (first == 0) first = k;
                pulses++;
            end
        end
        chk("jr_valid_latency", 32'(first), 32'd3);
        chk("jr_valid_pulses", 32'(pulses), 32'd1);
        chk("jr_rdata_held", jtag_rdata, 32'hDEADBEEF);

        // Address wrap: FF, 00, then 01
        jtag_load(8'hFF);
        jtag_write(32'h000000FF, 8'hFF);
        jtag_write(32'h00000100, 8'h00);
        jtag_write(32'h00000101, 8'h01);

        // Overflow: second pulse dropped while an Avalon read is in flight;
        // a coincident clear loses to the set
        @(posedge clk); #1;
        av_read = 1'b1; av_address = 8'h21; av_byteenable = 4'hF;
        jtag_addr_load = 1'b1; jtag_addr_in = 8'h30;
        push_acc(8'h21, 1'b0, 4'hF, 32'h0);
        exp_avrd.push_back(32'hCAFEF00D);
        push_acc(8'h30, 1'b1, 4'hF, 32'h11111111);
        @(posedge clk); #1;
        jtag_addr_load = 1'b0;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'h11111111;
        @(posedge clk); #1;
        jtag_wdata = 32'h22222222; jtag_ovf_clr = 1'b1;
        @(negedge clk);
        chk("ovf_before_drop", 32'(jtag_overflow), 32'd0);
        @(posedge clk); #1;
        av_read = 1'b0; jtag_req = 1'b0; jtag_ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_set", 32'(jtag_overflow), 32'd1);
        wait_jtag_idle("ovf_jtag_done");
        @(posedge clk); #1;
        jtag_ovf_clr = 1'b1;
        @(posedge clk); #1;
        jtag_ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(jtag_overflow), 32'd0);

        // Fresh reset, then both sources held: JTAG, Avalon, JTAG, Avalon
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        av_read = 1'b1; av_address = 8'h21; av_byteenable = 4'hF;
        jtag_req = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hA0A0A0A0;
        push_acc(8'h00, 1'b1, 4'hF, 32'hA0A0A0A0);
        push_acc(8'h21, 1'b0, 4'hF, 32'h0);
        push_acc(8'h01, 1'b1, 4'hF, 32'hB1B1B1B1);
        push_acc(8'h21, 1'b0, 4'hF, 32'h0);
        exp_avrd.push_back(32'hCAFEF00D);
        exp_avrd.push_back(32'hCAFEF00D);
        @(posedge clk); #1;
        jtag_wdata = 32'hB1B1B1B1;
        @(posedge clk); #1;
        jtag_req = 1'b0;
        done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (av_read && !av_waitrequest) done++;
            if (done == 2) break;
        end
        @(posedge clk); #1;
        av_read = 1'b0;
        chk("rr_av_completions", 32'(done), 32'd2);
        chk("rr_no_overflow", 32'(jtag_overflow), 32'd0);
        wait_jtag_idle("rr_jtag_idle");

        // Normal read of 01, then a read aborted by reset in RDATA
        jtag_load(8'h01);
        @(posedge clk); #1;
        jtag_req = 1'b1; jtag_wr = 1'b0;
        push_acc(8'h01, 1'b0, 4'hF, 32'h0);
        exp_jrd.push_back(32'hB1B1B1B1);
        @(posedge clk); #1;
        jtag_req = 1'b0;
        wait_jtag_idle("rd01_done");
        repeat (2) @(negedge clk);
        jv0 = jv_count;
        jtag_load(8'h10);
        @(posedge clk); #1;
        jtag_req = 1'b1; jtag_wr = 1'b0;
        push_acc(8'h10, 1'b0, 4'hF, 32'h0);
        @(posedge clk); #1;
        jtag_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_rdata", 32'(jtag_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(jtag_busy), 32'd0);
        chk("abort_waitrequest", 32'(av_waitrequest), 32'd1);
        chk("abort_jtag_rdata", jtag_rdata, 32'h0);
        chk("abort_ram_addr_be", {20'h0, ram_addr, ram_be}, 32'h0);
        chk("abort_ram_ctl", {30'h0, ram_en, ram_we}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_valid", 32'(jv_count), 32'(jv0));
        chk("abort_no_access", 32'(ram_en), 32'd0);

        chk("left_acc", 32'(exp_acc.size()), 32'd0);
        chk("left_jrd", 32'(exp_jrd.size()), 32'd0);
        chk("left_avrd", 32'(exp_avrd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
